// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a 3-sample majority vote per bit, framing and
// parity error flags, and a first-word-fall-through RX FIFO read through the
// i_iocs/i_iorw strobe. Timing comes only from the b_en oversample tick.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit and the i_par_odd input.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low at a tick
// START  | start bit: checked at MID, held until the bit ends
// DATA   | DATA_BITS payload bits, one vote per bit
// PARITY | parity bit checked against the payload (UART_RX_PARITY_EN only)
// STOP   | stop bit sampled, word pushed, back to IDLE half way through the bit
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_en,
`ifdef UART_RX_PARITY_EN
  input  logic                 i_par_odd,
`endif
  input  logic                 i_rx,
  input  logic                 i_iocs,
  input  logic                 i_iorw,
  output logic                 o_rda,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_ferr,
  output logic                 o_perr,
  output logic                 o_oerr
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int CW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_MID_M1 = TW'(MID - 1);
  localparam logic [TW-1:0] T_MID    = TW'(MID);
  localparam logic [TW-1:0] T_MID_P1 = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 r_rx_m, r_rx_s;
  logic [2:0]           r_state;
  logic [TW-1:0]        r_tick;
  logic [CW-1:0]        r_bitcnt;
  logic [1:0]           r_smp;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_perr;
  logic                 r_push;
  logic [EW-1:0]        r_word;
  logic                 w_vote;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wp, r_rp;
  logic                 r_oerr;
  logic                 w_empty, w_full, w_pop, w_wr;
  logic [EW-1:0]        w_head;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= i_rx;
      r_rx_s <= r_rx_m;
    end
  end

  // Third sample is taken live at MID+1, so the vote is valid exactly on that tick.
  assign w_vote = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_rx_s) | (r_smp[0] & r_rx_s);

  // Receive FSM; the tick counter restarts at each bit boundary, so MID is bit centre.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_smp    <= '0;
      r_shreg  <= '0;
      r_perr   <= 1'b0;
      r_push   <= 1'b0;
      r_word   <= '0;
    end else begin
      r_push <= 1'b0;
      if (b_en) begin
        if (r_state != S_IDLE) begin
          r_tick <= (r_tick == T_LAST) ? '0 : r_tick + 1'b1;
          if (r_tick == T_MID_M1 || r_tick == T_MID)
            r_smp <= {r_smp[0], r_rx_s};
        end
        case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_tick   <= '0;
              r_bitcnt <= '0;
              r_perr   <= 1'b0;
              r_state  <= S_START;
            end
          end
          S_START: begin
            if (r_tick == T_MID && r_rx_s)
              r_state <= S_IDLE;
            else if (r_tick == T_LAST)
              r_state <= S_DATA;
          end
          S_DATA: begin
            if (r_tick == T_MID_P1) begin
              if (MSB_FIRST != 0)
                r_shreg <= {r_shreg[DATA_BITS-2:0], w_vote};
              else
                r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
            end
            if (r_tick == T_LAST) begin
              if (r_bitcnt == C_LAST) begin
                r_bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
                r_state  <= S_PARITY;
`else
                r_state  <= S_STOP;
`endif
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (r_tick == T_MID_P1) begin
              r_perr  <= w_vote != ((^r_shreg) ^ i_par_odd);
              r_state <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            if (r_tick == T_MID_P1) begin
              r_push  <= 1'b1;
              r_word  <= {r_shreg, ~w_vote, r_perr};
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = i_iocs & i_iorw & ~w_empty;
  // A pop frees the slot in the same clk, so push-while-full-with-pop is accepted.
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rp[AW-1:0]];

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp[AW-1:0]] <= r_word;
  end

  // Pointers and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_oerr <= 1'b0;
    end else begin
      if (w_wr)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (r_push && w_full && !w_pop)
        r_oerr <= 1'b1;
      else if (w_pop)
        r_oerr <= 1'b0;
    end
  end

  assign o_rda  = ~w_empty;
  assign o_data = w_empty ? '0 : w_head[EW-1:2];
  assign o_ferr = w_empty ? 1'b0 : w_head[1];
  assign o_perr = w_empty ? 1'b0 : w_head[0];
  assign o_oerr = r_oerr;

endmodule
